atconv_pool_engine: RTL and testbench
=====================================

Name: atconv_pool_engine

Overview:
Parametrised successor of the layer-0/layer-1 atrous-convolution engine. It reads a square IMG_W x IMG_W fixed-point image from a synchronous image ROM and applies a 3x3 shift-weight kernel with run-time dilation and clamp-to-edge padding, plus bias. It then applies saturation and ReLU, and writes layer 0. Optionally it performs 2x2 max-pooling with ceiling-to-integer rounding into layer 1. Adds start/done handshake, saturation and a layer-0-only mode.

Parameters:
LOG_W, 6, log2 of image width; IMG_W = 2**LOG_W; image address width AW = 2*LOG_W
DW, 13, signed data width, two's complement
FRAC, 4, fractional bits of the data format
BIAS, 13'h1FF4, signed bias added once per pixel (default -0.75)
SH_C / SH_TB / SH_LR / SH_D, 0 / 3 / 2 / 4, shift amounts:
- centre weight is +2^-SH_C.
- top/bottom, left/right and diagonal weights are -2^-SH.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
start  in  1  one-cycle start pulse; sampled only in IDLE
dil  in  2  dilation 1..3 (0 treated as 1), latched at start
pool_en  in  1  1: layer0+layer1 mode; 0: layer0 only; latched at start
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse at end of frame
iaddr  out  AW  image ROM address; idata is valid the cycle after
idata  in  DW  signed image pixel
cwr  out  1  result-memory write strobe
csel  out  1  0 = layer0, 1 = layer1
caddr_wr  out  AW  write address
cdata_wr  out  DW  write data

Behaviour:
- Reset (async, active low):
  - Outputs: busy=0, done=0, cwr=0, csel=0, iaddr=0, caddr_wr=0, cdata_wr=0.
  - FSM returns to IDLE. A mid-frame reset aborts with no further writes.
- FSM states: IDLE -> FETCH -> ACC -> WR_L0 -> (WR_L1) -> FETCH... -> FIN -> IDLE.
- IDLE: start=1 latches dil/pool_en, clears counters, and enters FETCH with busy=1 next cycle. start while busy is ignored.
- FETCH: 9 cycles. Tap k=0..8 address presented in cycle k. Order: centre, TL, T, TR, L, R, BL, B, BR. Tap (r+dr*d, c+dc*d) is clamped per axis to [0, IMG_W-1].
- Accumulation: the tap k product is added in cycle k+1.
- ACC: adds the last tap. The accumulator is DW+4 bits, initialised to sign-extended BIAS at each pixel start. Weighted terms are idata arithmetically right-shifted by SH, negated for non-centre taps.
- WR_L0: cwr=1, csel=0, caddr_wr = r*IMG_W+c. cdata_wr is computed from acc:
  - Saturate acc to [-(2^(DW-1)), 2^(DW-1)-1].
  - Apply ReLU: negative becomes 0.
- Pixel order:
  - pool_en=1: 2x2-block raster order (r,c), (r,c+1), (r+1,c), (r+1,c+1); blocks in raster order.
  - pool_en=0: plain raster order.
- WR_L1: only when pool_en=1, after the 4th layer-0 write of a block.
  - cwr=1, csel=1, caddr_wr = (r/2)*(IMG_W/2)+(c/2).
  - cdata_wr = ceil-to-integer of the max of the 4 ReLU values; the fraction bits are zero.
  - If rounding overflows the positive range, the result is the largest integer 2^(DW-1)-2^FRAC.
- cwr is high only in WR_L0/WR_L1 cycles, otherwise 0.
- Latency: 11 cycles per pixel, plus 1 per block in pool mode.
- FIN: after the last write, busy=0 and a done pulse are both asserted in the same cycle, then IDLE.
- Address wrap: no wrap beyond IMG_W*IMG_W-1. The last pixel write goes to addr IMG_W^2-1, followed by FIN.

Test Plan:
- All-zero image, defaults, pool_en=1 -> every layer0 word 0x0000 (bias -0.75 ReLU'd), every layer1 word 0x0000; 4096+1024 writes; done once; busy high 46080 cycles.
- Image zero except (10,10)=0x080 (8.0), dil=2 -> layer0[650]=0x074 (7.25); layer0[652]=0x0000; layer1[165]=0x080.
- Image zero except (0,0)=0x100 (16.0), dil=2 -> clamped taps give layer0[0]=0x084 (8.25); layer1[0]=0x090 (9.0).
- (32,32)=0x0FFF, all others 0x1000, dil=2 -> layer0[2080]=0x0FFF (saturated); layer1[528]=0x0FF0 (round overflow clamp).
- pool_en=0, dil=1, impulse 0x080 at (5,5) -> raster-order layer0 writes only, no csel=1 ever; layer0[325]=0x074; layer0[326]=0x0000 (-2.0-0.75 ReLU'd).
- Assert reset for 1 cycle at write 100 -> outputs 0 immediately; second start then completes a full frame with correct data.

Source files
------------

// File: rtl/atconv_pool_engine_if.sv
// Bus between the atrous-convolution/pooling engine and its surroundings:
// the control handshake, the image ROM port and the result-memory write port.
interface atconv_pool_engine_if #(
    parameter int LOG_W = 6,
    parameter int DW    = 13
);
    localparam int AW = 2 * LOG_W;

    // start is a one-cycle request honoured only while idle. busy rises the
    // next cycle and falls in the same cycle as the one-cycle done pulse.
    // The write port has no backpressure: every cycle with cwr=1 is one write.
    logic          start;
    logic [1:0]    dil;
    logic          pool_en;
    logic          busy;
    logic          done;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    logic          cwr;
    logic          csel;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic [2:0]    state_dbg;

    modport master (
        input  start, dil, pool_en, idata,
        output busy, done, iaddr, cwr, csel, caddr_wr, cdata_wr, state_dbg
    );

    modport slave (
        output start, dil, pool_en, idata,
        input  busy, done, iaddr, cwr, csel, caddr_wr, cdata_wr, state_dbg
    );
endinterface

// File: rtl/atconv_pool_engine.sv
// 3x3 shift-weight atrous convolution with clamp-to-edge padding, bias,
// saturation and ReLU into layer 0, plus optional 2x2 ceil max-pool into layer 1.
module atconv_pool_engine #(
    parameter int            LOG_W = 6,
    parameter int            DW    = 13,
    parameter int            FRAC  = 4,
    parameter logic [DW-1:0] BIAS  = 13'h1FF4,
    parameter int            SH_C  = 0,
    parameter int            SH_TB = 3,
    parameter int            SH_LR = 2,
    parameter int            SH_D  = 4
) (
    input logic                  clk,
    input logic                  reset,
    atconv_pool_engine_if.master bus
);
    localparam int AW  = 2 * LOG_W;
    localparam int ACW = DW + 4;
    localparam logic signed [LOG_W+2:0] MAX_COORD = {3'b000, {LOG_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ACC   = 3'd2,
        S_WR_L0 = 3'd3,
        S_WR_L1 = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t                  state, state_nxt;
    logic [3:0]              tap;
    logic [AW-1:0]           pix;
    logic [1:0]              dil_q;
    logic                    pool_q;
    logic signed [ACW-1:0]   acc;
    logic [DW-1:0]           pool_max;

    logic [1:0]              deff;
    logic [LOG_W-1:0]        row, col, tap_r, tap_c;
    logic [3:0]              wk;
    logic signed [ACW-1:0]   px, term;
    logic [DW-1:0]           relu, pool_out;
    logic [DW:0]             rnd, rnd_int;

    // Tap order: centre, TL, T, TR, L, R, BL, B, BR. Direction code 01=+1, 11=-1.
    function automatic logic [1:0] tap_dr(input logic [3:0] k);
        case (k)
            4'd1, 4'd2, 4'd3: tap_dr = 2'b11;
            4'd6, 4'd7, 4'd8: tap_dr = 2'b01;
            default:          tap_dr = 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] tap_dc(input logic [3:0] k);
        case (k)
            4'd1, 4'd4, 4'd6: tap_dc = 2'b11;
            4'd3, 4'd5, 4'd8: tap_dc = 2'b01;
            default:          tap_dc = 2'b00;
        endcase
    endfunction

    function automatic logic [LOG_W-1:0] clamp_axis(input logic [LOG_W-1:0] base,
                                                    input logic [1:0] dir,
                                                    input logic [1:0] d);
        logic signed [LOG_W+2:0] p, b_ext, d_ext;
        b_ext = {3'b000, base};
        d_ext = {{(LOG_W+1){1'b0}}, d};
        case (dir)
            2'b01:   p = b_ext + d_ext;
            2'b11:   p = b_ext - d_ext;
            default: p = b_ext;
        endcase
        if (p[LOG_W+2])
            clamp_axis = '0;
        else if (p > MAX_COORD)
            clamp_axis = '1;
        else
            clamp_axis = p[LOG_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_FETCH;
            S_FETCH: if (tap == 4'd8) state_nxt = S_ACC;
            S_ACC:   state_nxt = S_WR_L0;
            S_WR_L0: begin
                if (pool_q && (pix[1:0] == 2'b11))
                    state_nxt = S_WR_L1;
                else if (&pix)
                    state_nxt = S_FIN;
                else
                    state_nxt = S_FETCH;
            end
            S_WR_L1: state_nxt = (&pix) ? S_FIN : S_FETCH;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pool mode walks 2x2 blocks: pix = {block row, block col, dy, dx}.
    always_comb begin
        deff = (dil_q == 2'd0) ? 2'd1 : dil_q;
        if (pool_q) begin
            row = {pix[AW-1:LOG_W+1], pix[1]};
            col = {pix[LOG_W:2], pix[0]};
        end else begin
            row = pix[AW-1:LOG_W];
            col = pix[LOG_W-1:0];
        end
        tap_r = clamp_axis(row, tap_dr(tap), deff);
        tap_c = clamp_axis(col, tap_dc(tap), deff);

        // The ROM answers one cycle late, so the data arriving now is for the previous tap.
        wk = (state == S_ACC) ? 4'd8 : tap - 4'd1;
        px = {{(ACW-DW){bus.idata[DW-1]}}, bus.idata};
        case (wk)
            4'd0:       term = px >>> SH_C;
            4'd2, 4'd7: term = -(px >>> SH_TB);
            4'd4, 4'd5: term = -(px >>> SH_LR);
            default:    term = -(px >>> SH_D);
        endcase

        if (acc[ACW-1])
            relu = '0;
        else if (|acc[ACW-2:DW-1])
            relu = {1'b0, {(DW-1){1'b1}}};
        else
            relu = acc[DW-1:0];

        rnd     = {1'b0, pool_max} + {{(DW+1-FRAC){1'b0}}, {FRAC{1'b1}}};
        rnd_int = rnd & {{(DW+1-FRAC){1'b1}}, {FRAC{1'b0}}};
        if (rnd_int[DW] | rnd_int[DW-1])
            pool_out = {1'b0, {(DW-1-FRAC){1'b1}}, {FRAC{1'b0}}};
        else
            pool_out = rnd_int[DW-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tap      <= '0;
            pix      <= '0;
            dil_q    <= '0;
            pool_q   <= 1'b0;
            acc      <= '0;
            pool_max <= '0;
        end else begin
            tap <= (state == S_FETCH && tap != 4'd8) ? tap + 4'd1 : 4'd0;
            case (state)
                S_IDLE: if (bus.start) begin
                    dil_q    <= bus.dil;
                    pool_q   <= bus.pool_en;
                    pix      <= '0;
                    pool_max <= '0;
                end
                S_FETCH: begin
                    if (tap == 4'd0)
                        acc <= {{(ACW-DW){BIAS[DW-1]}}, BIAS};
                    else
                        acc <= acc + term;
                end
                S_ACC: acc <= acc + term;
                S_WR_L0: begin
                    if (relu > pool_max)
                        pool_max <= relu;
                    if (state_nxt == S_FETCH)
                        pix <= pix + 1'b1;
                end
                S_WR_L1: begin
                    pool_max <= '0;
                    if (state_nxt == S_FETCH)
                        pix <= pix + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy      = (state == S_FETCH) || (state == S_ACC) ||
                        (state == S_WR_L0) || (state == S_WR_L1);
        bus.done      = (state == S_FIN);
        bus.iaddr     = (state == S_FETCH) ? {tap_r, tap_c} : '0;
        bus.cwr       = 1'b0;
        bus.csel      = 1'b0;
        bus.caddr_wr  = '0;
        bus.cdata_wr  = '0;
        bus.state_dbg = state;
        if (state == S_WR_L0) begin
            bus.cwr      = 1'b1;
            bus.caddr_wr = {row, col};
            bus.cdata_wr = relu;
        end else if (state == S_WR_L1) begin
            bus.cwr      = 1'b1;
            bus.csel     = 1'b1;
            bus.caddr_wr = {2'b00, row[LOG_W-1:1], col[LOG_W-1:1]};
            bus.cdata_wr = pool_out;
        end
    end
endmodule

// File: tb/tb_atconv_pool_engine.sv
// Directed frames on a 16x16 image; every result-memory write is checked
// in order against a hand-derived expected write stream.
module tb_atconv_pool_engine;
    localparam int LOG_W = 4;
    localparam int DW    = 13;
    localparam int AW    = 2 * LOG_W;
    localparam int W     = 1 << LOG_W;
    localparam int N     = W * W;
    localparam int EW    = 1 + AW + DW;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    atconv_pool_engine_if #(.LOG_W(LOG_W), .DW(DW)) bus();

    atconv_pool_engine #(.LOG_W(LOG_W), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] rom    [N];
    logic [DW-1:0] exp_l0 [N];
    logic [DW-1:0] exp_l1 [N/4];
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    int n_vec    = 0;
    int n_err    = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int wr_cnt   = 0;

    always @(posedge clk) bus.idata <= rom[bus.iaddr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per DUT write.
    always @(negedge clk) begin
        if (bus.busy) busy_cnt++;
        if (bus.done) done_cnt++;
        if (bus.cwr) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got csel=%0d addr=0x%0h data=0x%0h, expected none",
                         bus.csel, bus.caddr_wr, bus.cdata_wr);
            end else begin
                mon_e = exp_q.pop_front();
                chk($sformatf("write_%0d{csel,addr,data}", wr_cnt),
                    32'({bus.csel, bus.caddr_wr, bus.cdata_wr}), 32'(mon_e));
            end
        end
    end

    task automatic fill_image(input logic [DW-1:0] v);
        for (int i = 0; i < N; i++) rom[i] = v;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < N; i++) exp_l0[i] = '0;
        for (int i = 0; i < N/4; i++) exp_l1[i] = '0;
    endtask

    task automatic push_frame(input bit pool);
        logic [AW-1:0] a;
        if (pool) begin
            for (int br = 0; br < W/2; br++) begin
                for (int bc = 0; bc < W/2; bc++) begin
                    for (int s = 0; s < 4; s++) begin
                        a = AW'((2*br + s/2) * W + 2*bc + s%2);
                        exp_q.push_back({1'b0, a, exp_l0[a]});
                    end
                    a = AW'(br * (W/2) + bc);
                    exp_q.push_back({1'b1, a, exp_l1[a]});
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                a = AW'(i);
                exp_q.push_back({1'b0, a, exp_l0[i]});
            end
        end
    endtask

    task automatic run_frame(input string tag, input logic [1:0] d, input bit pool, input bit spur);
        bit got_done;
        got_done = 1'b0;
        push_frame(pool);
        busy_cnt = 0;
        done_cnt = 0;
        wr_cnt   = 0;
        @(negedge clk);
        bus.dil     = d;
        bus.pool_en = pool;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (spur && i == 40) begin
                bus.start   = 1'b1;
                bus.dil     = 2'd3;
                bus.pool_en = ~pool;
            end else if (spur && i == 41) begin
                bus.start   = 1'b0;
                bus.dil     = d;
                bus.pool_en = pool;
            end
            if (bus.done) begin
                got_done = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
        repeat (3) @(negedge clk);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), pool ? 32'(N*11 + N/4) : 32'(N*11));
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_writes"}, 32'(wr_cnt), pool ? 32'(N + N/4) : 32'(N));
        chk({tag, "_pending_exp"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_idle_state"}, 32'(bus.state_dbg), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        bit hit;
        bus.start   = 1'b0;
        bus.dil     = 2'd0;
        bus.pool_en = 1'b0;
        fill_image('0);
        clear_exp();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_cwr", 32'(bus.cwr), 32'd0);
        chk("rst_csel", 32'(bus.csel), 32'd0);
        chk("rst_iaddr", 32'(bus.iaddr), 32'd0);
        chk("rst_caddr", 32'(bus.caddr_wr), 32'd0);
        chk("rst_cdata", 32'(bus.cdata_wr), 32'd0);
        chk("rst_state", 32'(bus.state_dbg), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // All-zero image: bias alone is negative, everything ReLUs to 0; a start mid-frame is ignored.
        run_frame("zero", 2'd2, 1'b1, 1'b1);

        // 8.0 impulse at (10,10): only its own pixel is positive (8 - 0.75).
        fill_image('0);
        rom[10*W+10] = 13'h0080;
        clear_exp();
        exp_l0[10*W+10] = 13'h0074;
        exp_l1[5*(W/2)+5] = 13'h0080;
        run_frame("impulse", 2'd2, 1'b1, 1'b0);

        // 16.0 at the corner: clamped TL, T and L taps fold back onto it: 16-1-2-4-0.75.
        fill_image('0);
        rom[0] = 13'h0100;
        clear_exp();
        exp_l0[0] = 13'h0084;
        exp_l1[0] = 13'h0090;
        run_frame("corner", 2'd2, 1'b1, 1'b0);

        // Max positive in a sea of -256.0: layer0 saturates, pooled ceil overflows and clamps.
        fill_image(13'h1000);
        rom[8*W+8] = 13'h0FFF;
        clear_exp();
        exp_l0[8*W+8] = 13'h0FFF;
        exp_l1[4*(W/2)+4] = 13'h0FF0;
        run_frame("saturate", 2'd2, 1'b1, 1'b0);

        // Background 1.0 sums to 0 before bias; a -16.0 spot at (5,5) lifts the pixels
        // that see it as L/R (+68), T/B (+34) or diagonal (+17) tap at distance 3.
        fill_image(13'h0010);
        rom[5*W+5] = 13'h1F00;
        clear_exp();
        exp_l0[5*W+8] = 13'h0038;
        exp_l0[5*W+2] = 13'h0038;
        exp_l0[2*W+5] = 13'h0016;
        exp_l0[8*W+5] = 13'h0016;
        exp_l0[2*W+2] = 13'h0005;
        exp_l0[2*W+8] = 13'h0005;
        exp_l0[8*W+2] = 13'h0005;
        exp_l0[8*W+8] = 13'h0005;
        exp_l1[2*(W/2)+4] = 13'h0040;
        exp_l1[2*(W/2)+1] = 13'h0040;
        exp_l1[1*(W/2)+2] = 13'h0020;
        exp_l1[4*(W/2)+2] = 13'h0020;
        exp_l1[1*(W/2)+1] = 13'h0010;
        exp_l1[1*(W/2)+4] = 13'h0010;
        exp_l1[4*(W/2)+1] = 13'h0010;
        exp_l1[4*(W/2)+4] = 13'h0010;
        run_frame("dil3_pool", 2'd3, 1'b1, 1'b0);

        // Layer-0-only raster mode; dil=0 behaves as dil=1.
        fill_image('0);
        rom[5*W+5] = 13'h0080;
        clear_exp();
        exp_l0[5*W+5] = 13'h0074;
        run_frame("raster_dil1", 2'd1, 1'b0, 1'b0);
        run_frame("raster_dil0", 2'd0, 1'b0, 1'b0);

        // Abort at the 100th write with an asynchronous reset, then a clean frame.
        fill_image('0);
        rom[10*W+10] = 13'h0080;
        clear_exp();
        exp_l0[10*W+10] = 13'h0074;
        exp_l1[5*(W/2)+5] = 13'h0080;
        push_frame(1'b1);
        wr_cnt = 0;
        hit = 1'b0;
        @(negedge clk);
        bus.dil     = 2'd2;
        bus.pool_en = 1'b1;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (bus.cwr && wr_cnt == 99) begin
                hit = 1'b1;
                break;
            end
        end
        chk("abort_reached_write100", 32'(hit), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_cwr", 32'(bus.cwr), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_csel", 32'(bus.csel), 32'd0);
        chk("abort_caddr", 32'(bus.caddr_wr), 32'd0);
        chk("abort_cdata", 32'(bus.cdata_wr), 32'd0);
        chk("abort_iaddr", 32'(bus.iaddr), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_more_writes", 32'(wr_cnt), 32'd99);
        chk("abort_idle_state", 32'(bus.state_dbg), 32'd0);
        run_frame("after_abort", 2'd2, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
